// File: rtl/seq_pattern_tx_if.sv
// Load port, bit-advance enable and serial output stream of seq_pattern_tx.
interface seq_pattern_tx_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
);
  logic             load_valid;
  logic             load_ready;
  logic [PAT_W-1:0] load_pattern;
  logic [CNT_W-1:0] load_reps;
  logic [GAP_W-1:0] load_gap;
  logic             bit_en;
  logic             out_bit;
  logic             out_valid;
  logic             frame_start;
  logic             busy;
  logic             done;

  modport master (
    output load_valid, load_pattern, load_reps, load_gap, bit_en,
    input  load_ready, out_bit, out_valid, frame_start, busy, done
  );

  modport slave (
    input  load_valid, load_pattern, load_reps, load_gap, bit_en,
    output load_ready, out_bit, out_valid, frame_start, busy, done
  );
endinterface

// File: rtl/seq_pattern_tx.sv
// Serial bit-pattern transmitter: sends a loaded pattern MSB-first, repeated
// reps times with gap zero bits between repetitions, one bit per enabled clock.
module seq_pattern_tx #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
) (
  input  logic clk,
  input  logic reset,
  seq_pattern_tx_if.slave bus
);
  localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_W - 1);

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

  state_t           state_q, state_n;
  logic [PAT_W-1:0] pat_q, pat_n;
  logic [GAP_W-1:0] gap_q, gap_n;
  logic [GAP_W-1:0] gcnt_q, gcnt_n;
  logic [CNT_W-1:0] rep_q, rep_n;
  logic [IDX_W-1:0] idx_q, idx_n;
  logic             accept;
  logic             valid_n, bit_n, frame_n, busy_n, done_n, ready_n;

  // Next-state and datapath update; outputs are derived from the next state
  // so that every output can be registered without adding latency.
  always_comb begin
    state_n = state_q;
    pat_n   = pat_q;
    gap_n   = gap_q;
    gcnt_n  = gcnt_q;
    rep_n   = rep_q;
    idx_n   = idx_q;
    accept  = bus.load_valid && bus.load_ready;

    case (state_q)
      IDLE: begin
        if (accept) begin
          pat_n   = bus.load_pattern;
          gap_n   = bus.load_gap;
          rep_n   = bus.load_reps;
          idx_n   = '0;
          state_n = (bus.load_reps != '0) ? SEND : DONE;
        end
      end
      SEND: begin
        if (bus.bit_en) begin
          if (idx_q == LAST_IDX) begin
            idx_n = '0;
            if (rep_q != '0) rep_n = rep_q - CNT_W'(1);
            if (rep_q <= CNT_W'(1)) begin
              state_n = DONE;
            end else if (gap_q != '0) begin
              state_n = GAP;
              gcnt_n  = gap_q;
            end
          end else begin
            idx_n = idx_q + IDX_W'(1);
          end
        end
      end
      GAP: begin
        if (bus.bit_en) begin
          gcnt_n = gcnt_q - GAP_W'(1);
          if (gcnt_q == GAP_W'(1)) state_n = SEND;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    valid_n = (state_n == SEND) || (state_n == GAP);
    bit_n   = (state_n == SEND) ? pat_n[LAST_IDX - idx_n] : 1'b0;
    frame_n = (state_n == SEND) && (idx_n == '0);
    busy_n  = (state_n != IDLE);
    done_n  = (state_n == DONE);
    ready_n = (state_n == IDLE);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      pat_q           <= '0;
      gap_q           <= '0;
      gcnt_q          <= '0;
      rep_q           <= '0;
      idx_q           <= '0;
      bus.out_valid   <= 1'b0;
      bus.out_bit     <= 1'b0;
      bus.frame_start <= 1'b0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.load_ready  <= 1'b0;
    end else begin
      state_q         <= state_n;
      pat_q           <= pat_n;
      gap_q           <= gap_n;
      gcnt_q          <= gcnt_n;
      rep_q           <= rep_n;
      idx_q           <= idx_n;
      bus.out_valid   <= valid_n;
      bus.out_bit     <= bit_n;
      bus.frame_start <= frame_n;
      bus.busy        <= busy_n;
      bus.done        <= done_n;
      bus.load_ready  <= ready_n;
    end
  end
endmodule

// File: tb/tb_seq_pattern_tx.sv
// Self-checking bench for seq_pattern_tx: each transfer's expected bit stream
// is built from the pattern/reps/gap rules and compared cycle by cycle.
module tb_seq_pattern_tx;
  localparam int PAT_W = 4;
  localparam int CNT_W = 8;
  localparam int GAP_W = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  seq_pattern_tx_if #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_W(GAP_W)) bus ();

  seq_pattern_tx #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Observed output vector: {out_valid, out_bit, frame_start, busy, done, load_ready}
  function automatic logic [5:0] obs();
    return {bus.out_valid, bus.out_bit, bus.frame_start, bus.busy, bus.done, bus.load_ready};
  endfunction

  // Drives one load and follows the whole transfer against the reference stream.
  // stall_at/stall_len force bit_en low while stream position stall_at is shown.
  task automatic xfer(input logic [PAT_W-1:0] pat, input int reps, input int gap,
                      input int stall_pct, input int stall_at, input int stall_len,
                      input bit hold_valid, input string tag, output int vcycles);
    bit q[$];
    bit f[$];
    int pos, t, stalled;
    bit en;
    logic [5:0] exp_v;
    vcycles = 0;
    for (int r = 0; r < reps; r++) begin
      for (int b = 0; b < PAT_W; b++) begin
        q.push_back(pat[PAT_W-1-b]);
        f.push_back(b == 0);
      end
      if (r < reps - 1)
        for (int g = 0; g < gap; g++) begin
          q.push_back(1'b0);
          f.push_back(1'b0);
        end
    end
    t = 0;
    while (bus.load_ready !== 1'b1 && t < 64) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (bus.load_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s ready_wait: load_ready=%b required 1", tag, bus.load_ready);
      return;
    end
    bus.load_valid   = 1'b1;
    bus.load_pattern = pat;
    bus.load_reps    = CNT_W'(reps);
    bus.load_gap     = GAP_W'(gap);
    bus.bit_en       = 1'($urandom_range(1));
    @(negedge clk);
    if (!hold_valid) bus.load_valid = 1'b0;
    bus.load_pattern = PAT_W'($urandom);
    bus.load_reps    = CNT_W'($urandom);
    bus.load_gap     = GAP_W'($urandom);
    pos = 0;
    stalled = 0;
    while (pos < q.size()) begin
      exp_v = {1'b1, q[pos], f[pos], 1'b1, 1'b0, 1'b0};
      n_checks++;
      if (obs() !== exp_v) begin
        n_fail++;
        $display("FAIL %s stream[%0d]: got %b required %b (valid,bit,frame,busy,done,ready)",
                 tag, pos, obs(), exp_v);
      end
      vcycles++;
      if (pos == stall_at && stalled < stall_len) begin
        en = 1'b0;
        stalled++;
      end else begin
        en = ($urandom_range(99) >= stall_pct);
      end
      bus.bit_en = en;
      if (hold_valid) bus.load_pattern = PAT_W'($urandom);
      @(negedge clk);
      if (en) pos++;
      if (vcycles > 20000) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s stream_timeout: pos=%0d required %0d", tag, pos, q.size());
        return;
      end
    end
    exp_v = 6'b000110;
    n_checks++;
    if (obs() !== exp_v) begin
      n_fail++;
      $display("FAIL %s done_cycle: got %b required %b", tag, obs(), exp_v);
    end
    bus.bit_en = 1'($urandom_range(1));
    @(negedge clk);
    exp_v = 6'b000001;
    n_checks++;
    if (obs() !== exp_v) begin
      n_fail++;
      $display("FAIL %s idle_after_done: got %b required %b", tag, obs(), exp_v);
    end
  endtask

  task automatic test_reset();
    bus.load_valid = 1'b0; bus.load_pattern = '0; bus.load_reps = '0;
    bus.load_gap = '0; bus.bit_en = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (obs() !== 6'b000000) begin
      n_fail++;
      $display("FAIL reset_values: got %b required 000000", obs());
    end
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (obs() !== 6'b000001) begin
      n_fail++;
      $display("FAIL ready_after_reset: got %b required 000001", obs());
    end
  endtask

  task automatic test_single();
    int vc;
    xfer(4'b1011, 1, 0, 0, -1, 0, 1'b0, "single", vc);
    n_checks++;
    if (vc !== 4) begin n_fail++; $display("FAIL single_len: got %0d required 4", vc); end
  endtask

  task automatic test_gap();
    int vc;
    xfer(4'b1011, 3, 2, 0, -1, 0, 1'b0, "gap", vc);
    n_checks++;
    if (vc !== 16) begin n_fail++; $display("FAIL gap_len: got %0d required 16", vc); end
    xfer(4'b0110, 2, 15, 0, -1, 0, 1'b0, "gap_max", vc);
    n_checks++;
    if (vc !== 23) begin n_fail++; $display("FAIL gap_max_len: got %0d required 23", vc); end
  endtask

  task automatic test_stall();
    int vc;
    xfer(4'b1011, 1, 0, 0, 1, 3, 1'b0, "stall", vc);
    n_checks++;
    if (vc !== 7) begin n_fail++; $display("FAIL stall_len: got %0d required 7", vc); end
  endtask

  task automatic test_empty();
    int vc;
    xfer(4'b1111, 0, 3, 0, -1, 0, 1'b0, "empty", vc);
    n_checks++;
    if (vc !== 0) begin n_fail++; $display("FAIL empty_len: got %0d required 0", vc); end
  endtask

  task automatic test_load_while_busy();
    int vc, t;
    xfer(4'b1001, 2, 0, 0, -1, 0, 1'b1, "busy_load", vc);
    n_checks++;
    if (vc !== 8) begin n_fail++; $display("FAIL busy_load_len: got %0d required 8", vc); end
    bus.load_pattern = 4'b0110;
    bus.load_reps    = CNT_W'(1);
    bus.load_gap     = '0;
    bus.bit_en       = 1'b1;
    @(negedge clk);
    bus.load_valid = 1'b0;
    n_checks++;
    if (obs() !== 6'b101100) begin
      n_fail++;
      $display("FAIL second_load_accept: got %b required 101100", obs());
    end
    t = 0;
    while (bus.load_ready !== 1'b1 && t < 32) begin @(negedge clk); t++; end
  endtask

  task automatic test_reset_mid();
    logic [PAT_W-1:0] pat;
    int t, vc;
    logic [5:0] exp_v;
    pat = 4'b1101;
    t = 0;
    while (bus.load_ready !== 1'b1 && t < 64) begin @(negedge clk); t++; end
    bus.load_valid = 1'b1; bus.load_pattern = pat;
    bus.load_reps = CNT_W'(3); bus.load_gap = '0; bus.bit_en = 1'b1;
    @(negedge clk);
    bus.load_valid = 1'b0;
    for (int p = 0; p <= 6; p++) begin
      exp_v = {1'b1, pat[PAT_W-1-(p % PAT_W)], (p % PAT_W) == 0, 1'b1, 1'b0, 1'b0};
      n_checks++;
      if (obs() !== exp_v) begin
        n_fail++;
        $display("FAIL pre_reset[%0d]: got %b required %b", p, obs(), exp_v);
      end
      if (p < 6) @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if (obs() !== 6'b000000) begin
      n_fail++;
      $display("FAIL mid_reset_values: got %b required 000000", obs());
    end
    @(negedge clk);
    n_checks++;
    if (obs() !== 6'b000001) begin
      n_fail++;
      $display("FAIL mid_reset_ready: got %b required 000001", obs());
    end
    xfer(4'b0111, 2, 1, 0, -1, 0, 1'b0, "post_reset", vc);
  endtask

  task automatic test_max_reps();
    int vc;
    xfer(4'b1010, 255, 0, 0, -1, 0, 1'b0, "max_reps", vc);
    n_checks++;
    if (vc !== 1020) begin n_fail++; $display("FAIL max_reps_len: got %0d required 1020", vc); end
  endtask

  task automatic test_random();
    int vc;
    for (int i = 0; i < 25; i++)
      xfer(PAT_W'($urandom), int'($urandom_range(4)), int'($urandom_range(3)),
           30, -1, 0, 1'b0, "random", vc);
  endtask

  initial begin
    test_reset();
    test_single();
    test_gap();
    test_stall();
    test_empty();
    test_load_while_busy();
    test_reset_mid();
    test_max_reps();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
